// File: rtl/traffic_light_timer.sv
// Dual independent green/yellow interval timer answering the intersection controller's start strobes.
// Optional countdown outputs remain_g_o/remain_y_o are enabled by defining TLT_REMAIN_OUT_EN.
module traffic_light_timer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
    localparam int TW = $clog2(((GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_g_i,
    input  logic          start_y_i,
    output logic          done_g_o,
    output logic          done_y_o,
    output logic          busy_g_o,
    output logic          busy_y_o
`ifdef TLT_REMAIN_OUT_EN
    ,
    output logic [TW-1:0] remain_g_o,
    output logic [TW-1:0] remain_y_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    if (TICK_DIV == 0)     $error("traffic_light_timer: TICK_DIV must be >= 1");
    if (GREEN_TICKS == 0)  $error("traffic_light_timer: GREEN_TICKS must be >= 1");
    if (YELLOW_TICKS == 0) $error("traffic_light_timer: YELLOW_TICKS must be >= 1");

    logic [1:0] start_v;
    logic [1:0] done_v;
    logic [1:0] busy_v;

    assign start_v  = {start_y_i, start_g_i};
    assign done_g_o = done_v[0];
    assign done_y_o = done_v[1];
    assign busy_g_o = busy_v[0];
    assign busy_y_o = busy_v[1];

    // Channel 0 times green, channel 1 times yellow; they share nothing but the clock.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        localparam int TICKS = (ch == 0) ? GREEN_TICKS : YELLOW_TICKS;

        state_e        state_q, state_d;
        logic [PW-1:0] pre_q,   pre_d;
        logic [TW-1:0] rem_q,   rem_d;
        logic          done_q,  done_d;
        logic          busy;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                pre_q   <= '0;
                rem_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                pre_q   <= pre_d;
                rem_q   <= rem_d;
                done_q  <= done_d;
            end
        end

        // A start always wins, including over an expiry on the same edge.
        always_comb begin
            // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
            state_d = state_q;
            pre_d   = pre_q;
            rem_d   = rem_q;
            done_d  = 1'b0;
            if (start_v[ch]) begin
                state_d = RUN;
                pre_d   = '0;
                rem_d   = TW'(TICKS);
            end else if (state_q == RUN) begin
                if (pre_q == PW'(TICK_DIV - 1)) begin
                    pre_d = '0;
                    if (rem_q == TW'(1)) begin
                        rem_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        end

        always_comb begin
            busy = (state_q == RUN);
        end

        assign busy_v[ch] = busy;
        assign done_v[ch] = done_q;

`ifdef TLT_REMAIN_OUT_EN
        if (ch == 0) begin : g_rem_g
            assign remain_g_o = rem_q;
        end else begin : g_rem_y
            assign remain_y_o = rem_q;
        end
`endif
    end

endmodule

// File: tb/tb_traffic_light_timer.sv
// Directed bench for traffic_light_timer: dut_a (TICK_DIV=1, G=5, Y=2) and dut_b (TICK_DIV=3, G=5, Y=2).
// Edge Ek is the k-th posedge of a scenario; outputs are sampled 1 ns after it.
module tb_traffic_light_timer;

    logic clk = 1'b0;
    logic reset;
    logic sg_a, sy_a, sg_b, sy_b;
    logic dg_a, dy_a, bg_a, by_a;
    logic dg_b, dy_b, bg_b, by_b;
`ifdef TLT_REMAIN_OUT_EN
    logic [2:0] rg_a, ry_a, rg_b, ry_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_light_timer #(.TICK_DIV(1), .GREEN_TICKS(5), .YELLOW_TICKS(2)) dut_a (
        .clk(clk), .reset(reset), .start_g_i(sg_a), .start_y_i(sy_a),
        .done_g_o(dg_a), .done_y_o(dy_a), .busy_g_o(bg_a), .busy_y_o(by_a)
`ifdef TLT_REMAIN_OUT_EN
        , .remain_g_o(rg_a), .remain_y_o(ry_a)
`endif
    );

    traffic_light_timer #(.TICK_DIV(3), .GREEN_TICKS(5), .YELLOW_TICKS(2)) dut_b (
        .clk(clk), .reset(reset), .start_g_i(sg_b), .start_y_i(sy_b),
        .done_g_o(dg_b), .done_y_o(dy_b), .busy_g_o(bg_b), .busy_y_o(by_b)
`ifdef TLT_REMAIN_OUT_EN
        , .remain_g_o(rg_b), .remain_y_o(ry_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        sg_a = 0; sy_a = 0; sg_b = 0; sy_b = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1; sg_a = 1; sy_a = 1; sg_b = 1; sy_b = 1;
        tick(); tick();
        got = {bg_a, dg_a, by_a, dy_a, bg_b, dg_b, by_b, dy_b};
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", got, 8'h00);
        end
`ifdef TLT_REMAIN_OUT_EN
        n_tests++;
        if ({rg_a, ry_a, rg_b, ry_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_remain: got %h expected 000", {rg_a, ry_a, rg_b, ry_b});
        end
`endif
        sg_a = 0; sy_a = 0; sg_b = 0; sy_b = 0;
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            got = {bg_a, dg_a, by_a, dy_a, bg_b, dg_b, by_b, dy_b};
            n_tests++;
            if (got !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_release k=%0d: got %b expected %b", k, got, 8'h00);
            end
        end
    endtask

    task automatic test_green();
        logic [3:0] got, exp;
        for (int k = 0; k <= 6; k++) begin
            sg_a = (k == 0);
            tick();
            sg_a = 0;
            got = {bg_a, dg_a, by_a, dy_a};
            exp = {k < 5, k == 5, 1'b0, 1'b0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL green E%0d: got %b expected %b", k, got, exp);
            end
`ifdef TLT_REMAIN_OUT_EN
            n_tests++;
            if (rg_a !== ((k < 5) ? 3'(5 - k) : 3'd0)) begin
                n_fail++;
                $display("FAIL green_remain E%0d: got %0d expected %0d", k, rg_a, (k < 5) ? 5 - k : 0);
            end
`endif
        end
    endtask

    task automatic test_yellow_prescale();
        logic [1:0] got, exp;
        logic [2:0] rexp;
        for (int k = 0; k <= 7; k++) begin
            sy_b = (k == 0);
            tick();
            sy_b = 0;
            got = {by_b, dy_b};
            exp = {k < 6, k == 6};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL yellow_prescale E%0d: got %b expected %b", k, got, exp);
            end
            rexp = (k < 3) ? 3'd2 : (k < 6) ? 3'd1 : 3'd0;
`ifdef TLT_REMAIN_OUT_EN
            n_tests++;
            if (ry_b !== rexp) begin
                n_fail++;
                $display("FAIL yellow_remain E%0d: got %0d expected %0d", k, ry_b, rexp);
            end
`endif
        end
    endtask

    task automatic test_restart();
        logic [1:0] got, exp;
        for (int k = 0; k <= 10; k++) begin
            sg_a = (k == 0 || k == 3);
            tick();
            sg_a = 0;
            got = {bg_a, dg_a};
            exp = {k < 8, k == 8};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL restart E%0d: got %b expected %b", k, got, exp);
            end
        end
        idle_gap();
        for (int k = 0; k <= 11; k++) begin
            sg_a = (k == 0 || k == 5);
            tick();
            sg_a = 0;
            got = {bg_a, dg_a};
            exp = {k < 10, k == 10};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL restart_at_expiry E%0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        for (int k = 0; k <= 6; k++) begin
            sg_a = (k == 0);
            sy_a = (k == 0);
            tick();
            sg_a = 0; sy_a = 0;
            got = {bg_a, dg_a, by_a, dy_a};
            exp = {k < 5, k == 5, k < 2, k == 2};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL simultaneous E%0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_held_start();
        logic [1:0] got, exp;
        for (int k = 0; k <= 13; k++) begin
            sg_a = (k < 8);
            tick();
            got = {bg_a, dg_a};
            exp = {k < 12, k == 12};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL held_start E%0d: got %b expected %b", k, got, exp);
            end
        end
        sg_a = 0;
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] got, exp;
        for (int k = 0; k <= 10; k++) begin
            sg_a  = (k == 0);
            sy_a  = (k == 2);
            reset = (k == 2);
            tick();
            sg_a = 0; sy_a = 0; reset = 0;
            got = {bg_a, dg_a, by_a, dy_a};
            exp = {k < 2, 1'b0, 1'b0, 1'b0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_run E%0d: got %b expected %b", k, got, exp);
            end
`ifdef TLT_REMAIN_OUT_EN
            n_tests++;
            if (rg_a !== ((k < 2) ? 3'(5 - k) : 3'd0)) begin
                n_fail++;
                $display("FAIL reset_mid_run_remain E%0d: got %0d expected %0d", k, rg_a, (k < 2) ? 5 - k : 0);
            end
`endif
        end
    endtask

    initial begin
        reset = 1; sg_a = 0; sy_a = 0; sg_b = 0; sy_b = 0;
        test_reset();
        idle_gap();
        test_green();
        idle_gap();
        test_yellow_prescale();
        idle_gap();
        test_restart();
        idle_gap();
        test_back_to_back();
        idle_gap();
        test_held_start();
        idle_gap();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_timer.md
# traffic_light_timer

Dual green/yellow interval timer that serves as the timing responder for the intersection FSM controller. It accepts the controller's start strobes, counts a configurable number of ticks derived from a clock prescaler, and returns a single-cycle done pulse per completed interval. The block sits beside the controller on the FPGA top level. Its start inputs connect to the controller's start-timer outputs, and its done outputs connect to the controller's timer-done inputs.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per timer tick (1 s at 50 MHz); legal range ≥1.
- GREEN_TICKS, default 5: green interval length in ticks; legal range ≥1.
- YELLOW_TICKS, default 2: yellow interval length in ticks; legal range ≥1.
- Derived localparams (not overridable):
  - PW = $clog2(TICK_DIV) (min 1).
  - TW = $clog2(max(GREEN_TICKS, YELLOW_TICKS)+1).

- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start_g_i  in  1  start/restart green interval; sampled every posedge
- start_y_i  in  1  start/restart yellow interval; sampled every posedge
- done_g_o  out  1  one-cycle pulse: green interval complete
- done_y_o  out  1  one-cycle pulse: yellow interval complete
- busy_g_o  out  1  green interval running
- busy_y_o  out  1  yellow interval running
- remain_g_o  out  TW  remaining green ticks (only with TLT_REMAIN_OUT_EN)
- remain_y_o  out  TW  remaining yellow ticks (only with TLT_REMAIN_OUT_EN)

## Operation
- Two identical, fully independent channels, G and Y. Each channel has:
  - a 2-state FSM: IDLE, RUN;
  - a prescaler counter pre (PW bits);
  - a remaining-tick counter rem (TW bits);
  - a done register.
- Reset: FSM=IDLE, pre=0, rem=0, done=0. Every output is 0.
- Start accepted: start_x_i=1 at a posedge, in any state. The channel then:
  - loads pre←0 and rem←X_TICKS;
  - enters RUN;
  - clears done on that edge.
  A start in RUN is a restart: the interval reloads, and the aborted run produces no done pulse.
- RUN, no start:
  - If pre==TICK_DIV-1: pre←0, rem←rem-1.
  - Otherwise: pre←pre+1.
- Expiry: in RUN with pre==TICK_DIV-1 and rem==1, the channel sets done←1, rem←0, and FSM←IDLE.
- Done is a registered pulse, cleared on the next edge unless expiry recurs. Expiry cannot recur in the next cycle, because a new run takes at least one tick.
- Simultaneous start and expiry on the same edge: start wins. The channel reloads, stays in RUN, and done stays 0.
- Simultaneous start_g_i and start_y_i: both accepted; the channels never interact.
- start_x_i held high continuously: the channel restarts every cycle and never completes.
- busy_x_o = (FSM==RUN), registered. It deasserts on the same edge at which done_x_o asserts.
- Parameter checks: TICK_DIV, GREEN_TICKS or YELLOW_TICKS equal to 0 triggers $error at elaboration.

## Timing
- Start sampled at edge E0 with no further start:
  - busy_x_o is high from E0 to E0+N·TICK_DIV;
  - done_x_o is high exactly between E0+N·TICK_DIV and E0+N·TICK_DIV+1;
  - N is the channel's tick count.
- The controller asserts start combinationally in the cycle of its state change, so the timer samples start on the edge where the controller enters the timed state.
- The controller samples done at E0+N·TICK_DIV+1, so the light state lasts N·TICK_DIV+1 cycles.
- Reset mid-run:
  - any pending interval is discarded;
  - no done pulse is emitted;
  - all outputs are 0 after the reset edge.
  Start is ignored while reset=1.
- No combinational path from inputs to outputs.

## Configuration
- Macro: TLT_REMAIN_OUT_EN.
- Defined:
  - ports remain_g_o and remain_y_o exist;
  - each is driven with the registered rem value of its channel, for seven-segment countdown display;
  - the value is X_TICKS right after start, decrements once per tick, and is 0 in IDLE and after reset.
- Undefined:
  - both ports are absent;
  - rem logic remains internal, and all other behaviour is identical.

## Test plan
- Reset: assert reset for 2 cycles while driving starts high → every output 0; no done on release with starts low.
- Green interval, TICK_DIV=1, GREEN_TICKS=5: start_g_i pulse at E0 →
  - busy_g_o high E0–E5;
  - done_g_o high for exactly one cycle, E5–E6;
  - Y channel outputs stay 0.
- Yellow with prescale, TICK_DIV=3, YELLOW_TICKS=2: start_y_i at E0 →
  - done_y_o high E6–E7;
  - with TLT_REMAIN_OUT_EN, remain_y_o reads 2 over E0–E3, 1 over E3–E6, and 0 from E6.
- Restart, TICK_DIV=1, G=5: start_g_i at E0 and again at E3 → no pulse at E5; done_g_o high E8–E9. Start at E5, coincident with expiry → no done at E5; done at E10.
- Simultaneous starts, TICK_DIV=1, G=5, Y=2: start_g_i and start_y_i both at E0 → done_y_o at E2, done_g_o at E5, each one cycle.
- Reset mid-run: start_g_i at E0, reset at E2 → busy_g_o 0 from E2; no done_g_o through E10.
